// File: rtl/display_pkg.sv
// Shared display constants for the ILI9341 pixel path.
// Holds panel geometry, pixel width and the colour-field positions that
// both the pixel framer and the display controller decode.
package display_pkg;

   localparam int unsigned DISP_WIDTH  = 320;
   localparam int unsigned DISP_HEIGHT = 240;
   localparam int unsigned DISP_PIXELS = DISP_WIDTH * DISP_HEIGHT;

   localparam int unsigned PIXEL_WIDTH = 16;

   // RGB565 field positions (msb / lsb)
   localparam int unsigned RGB565_R_MSB = 15;
   localparam int unsigned RGB565_R_LSB = 11;
   localparam int unsigned RGB565_G_MSB = 10;
   localparam int unsigned RGB565_G_LSB = 5;
   localparam int unsigned RGB565_B_MSB = 4;
   localparam int unsigned RGB565_B_LSB = 0;

   // RGBA4444 field positions (msb / lsb)
   localparam int unsigned RGBA4444_R_MSB = 15;
   localparam int unsigned RGBA4444_R_LSB = 12;
   localparam int unsigned RGBA4444_G_MSB = 11;
   localparam int unsigned RGBA4444_G_LSB = 8;
   localparam int unsigned RGBA4444_B_MSB = 7;
   localparam int unsigned RGBA4444_B_LSB = 4;
   localparam int unsigned RGBA4444_A_MSB = 3;
   localparam int unsigned RGBA4444_A_LSB = 0;

   // Counter width for n states, never narrower than one bit.
   function automatic int unsigned width_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_pixel_framer_if.sv
// AXI-stream bundle used on both sides of the pixel framer.
//   tvalid : beat/pixel valid (master -> slave)
//   tready : accept (slave -> master)
//   tlast  : end of frame marker (master -> slave)
//   tdata  : payload, DATA_WIDTH bits (master -> slave)
interface display_pixel_framer_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input  tready);
   modport slave  (input  tvalid, input  tlast, input  tdata, output tready);
endinterface

// File: rtl/display_pixel_framer.sv
// Unpacks wide framebuffer beats into single 16-bit pixels for the display
// controller, regenerates tlast on the last pixel of each frame and flags
// frames whose length differs from FRAME_PIXELS.
// Ports:
//   aclk, resetn : clock, asynchronous active-low reset
//   s_axis       : slave stream of DATA_WIDTH-bit beats (PPB packed pixels)
//   m_axis       : master stream of 16-bit pixels
//   frame_done   : one-cycle pulse after a tlast pixel handshakes
//   err_short    : sticky, input tlast before FRAME_PIXELS pixels
//   err_long     : sticky, FRAME_PIXELS reached without input tlast
//   clear_err    : synchronous clear of both error flags (set wins)
module display_pixel_framer
   import display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FRAME_PIXELS = DISP_PIXELS,
   parameter bit          LSB_FIRST    = 1'b1
) (
   input  logic                  aclk,
   input  logic                  resetn,
   display_pixel_framer_if.slave  s_axis,
   display_pixel_framer_if.master m_axis,
   output logic                  frame_done,
   output logic                  err_short,
   output logic                  err_long,
   input  logic                  clear_err
);

   localparam int unsigned PPB   = DATA_WIDTH / PIXEL_WIDTH;
   localparam int unsigned IDX_W = width_min1(PPB);
   localparam int unsigned CNT_W = width_min1(FRAME_PIXELS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPB - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

   logic                   loaded_q, loaded_d;
   logic [DATA_WIDTH-1:0]  beat_q, beat_d;
   logic                   beat_last_q, beat_last_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
   logic                   frame_done_q, frame_done_d;
   logic                   err_short_q, err_short_d;
   logic                   err_long_q, err_long_d;

   logic                   last_of_beat;
   logic                   frame_end;
   logic                   out_last;
   logic                   m_hs;
   logic                   s_ready;
   logic                   s_hs;
   logic                   set_short;
   logic                   set_long;
   logic [IDX_W-1:0]       slot;
   logic [PIXEL_WIDTH-1:0] pixel;

   always_comb begin
      last_of_beat = (idx_q == IDX_LAST);
      frame_end    = (pix_cnt_q == CNT_LAST);
      out_last     = frame_end || (beat_last_q && last_of_beat);
      m_hs         = loaded_q && m_axis.tready;
      // Refill in the same cycle the last pixel of the held beat leaves.
      s_ready      = resetn && (!loaded_q || (m_hs && last_of_beat));
      s_hs         = s_axis.tvalid && s_ready;
      set_short    = m_hs && beat_last_q && last_of_beat && !frame_end;
      set_long     = m_hs && frame_end && !(beat_last_q && last_of_beat);

      // MSB-first beats hold logical pixel 0 in the top slot.
      slot  = LSB_FIRST ? idx_q : (IDX_LAST - idx_q);
      pixel = '0;
      for (int unsigned i = 0; i < PPB; i++) begin
         if (slot == IDX_W'(i)) pixel = beat_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   always_comb begin
      loaded_d     = loaded_q;
      beat_d       = beat_q;
      beat_last_d  = beat_last_q;
      idx_d        = idx_q;
      pix_cnt_d    = pix_cnt_q;
      frame_done_d = 1'b0;

      if (m_hs) begin
         if (last_of_beat) begin
            idx_d    = '0;
            loaded_d = 1'b0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
         if (out_last) begin
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end

      if (s_hs) begin
         loaded_d    = 1'b1;
         beat_d      = s_axis.tdata;
         beat_last_d = s_axis.tlast;
         idx_d       = '0;
      end

      err_short_d = set_short || (err_short_q && !clear_err);
      err_long_d  = set_long  || (err_long_q  && !clear_err);
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         loaded_q     <= 1'b0;
         beat_q       <= '0;
         beat_last_q  <= 1'b0;
         idx_q        <= '0;
         pix_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
         err_long_q   <= 1'b0;
      end else begin
         loaded_q     <= loaded_d;
         beat_q       <= beat_d;
         beat_last_q  <= beat_last_d;
         idx_q        <= idx_d;
         pix_cnt_q    <= pix_cnt_d;
         frame_done_q <= frame_done_d;
         err_short_q  <= err_short_d;
         err_long_q   <= err_long_d;
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = loaded_q;
   assign m_axis.tdata  = pixel;
   assign m_axis.tlast  = out_last;
   assign frame_done    = frame_done_q;
   assign err_short     = err_short_q;
   assign err_long      = err_long_q;

endmodule

// File: tb/tb_display_pixel_framer.sv
// Randomized self-checking bench for display_pixel_framer. Three
// configurations run side by side, each against a queue-based model of the
// pixel stream and frame rules.
module tb_display_pixel_framer;

   typedef struct {
      logic [15:0] pix;
      bit          last;
   } exp_pix_t;

   localparam int unsigned NCFG = 3;
   localparam int unsigned CFG_DW  [NCFG] = '{32, 32, 64};
   localparam int unsigned CFG_FP  [NCFG] = '{8, 6, 10};
   localparam int unsigned CFG_LSB [NCFG] = '{1, 1, 0};
   localparam int unsigned N_CYC = 700;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mark_done();
      n_done++;
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
      localparam int unsigned DW  = CFG_DW[g];
      localparam int unsigned FP  = CFG_FP[g];
      localparam int unsigned PPB = DW / 16;
      localparam bit          LSB = (CFG_LSB[g] != 0);

      logic resetn;
      logic clear_err;
      logic frame_done, err_short, err_long;

      display_pixel_framer_if #(.DATA_WIDTH(DW)) s_if ();
      display_pixel_framer_if #(.DATA_WIDTH(16)) m_if ();

      display_pixel_framer #(
         .DATA_WIDTH  (DW),
         .FRAME_PIXELS(FP),
         .LSB_FIRST   (LSB)
      ) dut (
         .aclk      (clk),
         .resetn    (resetn),
         .s_axis    (s_if.slave),
         .m_axis    (m_if.master),
         .frame_done(frame_done),
         .err_short (err_short),
         .err_long  (err_long),
         .clear_err (clear_err)
      );

      initial begin
         exp_pix_t    q[$];
         exp_pix_t    e;
         logic [15:0] cur_pix [4];
         logic [63:0] beat;
         logic [15:0] seq;
         bit          cur_last, pend, first_beat;
         bit          exp_valid, exp_sready, exp_last;
         bit          set_s, set_l, es, el, fd, fd_next;
         int unsigned fcnt, bif, flen, nframes;
         string       p;

         p = $sformatf("c%0d", g);
         resetn       = 1'b0;
         clear_err    = 1'b0;
         s_if.tvalid  = 1'b0;
         s_if.tlast   = 1'b0;
         s_if.tdata   = '0;
         m_if.tready  = 1'b1;
         seq = 16'h0100; pend = 0; first_beat = 1;
         fcnt = 0; bif = 0; flen = FP / PPB; nframes = 0;
         es = 0; el = 0; fd = 0;

         repeat (3) @(posedge clk);
         #1;
         chk({p, "/rst_valid"}, 32'(m_if.tvalid), 0);
         chk({p, "/rst_sready"}, 32'(s_if.tready), 0);
         chk({p, "/rst_tdata"}, 32'(m_if.tdata), 0);
         chk({p, "/rst_tlast"}, 32'(m_if.tlast), 0);
         chk({p, "/rst_errs"}, {29'd0, frame_done, err_short, err_long}, 0);
         resetn = 1'b1;

         for (int unsigned cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == N_CYC / 2) begin
               // asynchronous reset mid-frame, observed before any clock edge
               resetn      = 1'b0;
               s_if.tvalid = 1'b0;
               clear_err   = 1'b0;
               #1;
               chk({p, "/mid_rst_valid"}, 32'(m_if.tvalid), 0);
               chk({p, "/mid_rst_sready"}, 32'(s_if.tready), 0);
               chk({p, "/mid_rst_tdata"}, 32'(m_if.tdata), 0);
               chk({p, "/mid_rst_flags"}, {29'd0, frame_done, err_short, err_long}, 0);
               q.delete();
               fcnt = 0; bif = 0; flen = FP / PPB; pend = 0;
               es = 0; el = 0; fd = 0;
               @(posedge clk);
               #1;
               resetn = 1'b1;
            end

            if (!pend) begin
               s_if.tvalid = 1'b0;
               if ($urandom_range(0, 99) < 85) begin
                  beat = '0;
                  for (int unsigned k = 0; k < PPB; k++) begin
                     if (first_beat) cur_pix[k] = 16'((k + 1) * 16'h1111);
                     else begin
                        cur_pix[k] = seq;
                        seq++;
                     end
                     if (LSB) beat[k*16 +: 16] = cur_pix[k];
                     else     beat[(PPB-1-k)*16 +: 16] = cur_pix[k];
                  end
                  first_beat = 0;
                  bif++;
                  cur_last = (bif == flen);
                  if (cur_last) begin
                     bif = 0;
                     nframes++;
                     if (nframes < 3 || $urandom_range(0, 99) < 50) flen = FP / PPB;
                     else flen = $urandom_range(1, 2 * FP / PPB + 1);
                  end
                  s_if.tdata  = beat[DW-1:0];
                  s_if.tlast  = cur_last;
                  s_if.tvalid = 1'b1;
                  pend = 1;
               end
            end

            if (cyc < 80)       m_if.tready = 1'b1;
            else if (cyc < 160) m_if.tready = cyc[0];
            else                m_if.tready = ($urandom_range(0, 99) < 75);
            clear_err = ($urandom_range(0, 99) < 4);

            @(negedge clk);
            exp_valid  = (q.size() != 0);
            exp_sready = (q.size() == 0) || (m_if.tready && q.size() == 1);
            chk({p, "/m_tvalid"}, 32'(m_if.tvalid), 32'(exp_valid));
            chk({p, "/s_tready"}, 32'(s_if.tready), 32'(exp_sready));
            chk({p, "/frame_done"}, 32'(frame_done), 32'(fd));
            chk({p, "/err_short"}, 32'(err_short), 32'(es));
            chk({p, "/err_long"}, 32'(err_long), 32'(el));

            set_s = 0; set_l = 0; fd_next = 0;
            if (exp_valid) begin
               e = q[0];
               exp_last = (fcnt == FP - 1) || e.last;
               chk({p, "/m_tdata"}, 32'(m_if.tdata), 32'(e.pix));
               chk({p, "/m_tlast"}, 32'(m_if.tlast), 32'(exp_last));
               if (m_if.tready) begin
                  set_s = e.last && (fcnt != FP - 1);
                  set_l = (fcnt == FP - 1) && !e.last;
                  if (exp_last) begin
                     fcnt = 0;
                     fd_next = 1;
                  end else begin
                     fcnt++;
                  end
                  void'(q.pop_front());
               end
            end
            es = set_s || (es && !clear_err);
            el = set_l || (el && !clear_err);
            fd = fd_next;

            if (s_if.tvalid && exp_sready) begin
               for (int unsigned k = 0; k < PPB; k++) begin
                  e.pix  = cur_pix[k];
                  e.last = cur_last && (k == PPB - 1);
                  q.push_back(e);
               end
               pend = 0;
            end
         end
         mark_done();
      end
   end

   initial begin
      for (int i = 0; i < 20000 && n_done < int'(NCFG); i++) @(posedge clk);
      chk("all_cfg_done", 32'(n_done), NCFG);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
